sd_cmd_tx: RTL and testbench

Host-to-card command transmitter for the SD host CMD line. It is the outbound counterpart to the 128-bit response capture register. It latches a 6-bit command index and a 32-bit argument, then builds the 48-bit SD command frame with a serially computed CRC7. It shifts the frame out MSB-first, one bit per bit-enable tick, and reports completion to the command-control logic.

---
 rtl/sd_cmd_pkg.sv | 34 +++
 rtl/sd_crc7_serial.sv | 38 +++
 rtl/sd_cmd_tx.sv | 187 ++++++++++++++++++
 tb/tb_sd_cmd_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD host command transmitter.
// Optional Ncc trailer is selected by SD_CMD_TX_NCC_EN.
package sd_cmd_pkg;

  localparam int CMD_FRAME_W = 48;
  localparam int CMD_CRC_W   = 7;
  localparam int CNT_W       = 6;
  localparam int NCC_TICKS   = 8;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam logic START_BIT = 1'b0;
  localparam logic TX_BIT    = 1'b1;
  localparam logic END_BIT   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    SEND,
    NCC,
    DONE
  } tx_state_e;

  // One serial CRC7 step (x^7 + x^3 + 1).
  function automatic logic [6:0] crc7_step(
    input logic [6:0] crc,
    input logic       din
  );
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 generator, shared with the response CRC checker.
// Feeding din = crc[6] shifts the register left with zero fill.
module sd_crc7_serial
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;

  // Next CRC: clear wins over update.
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = crc7_step(crc_q, din);
    end
  end

  // CRC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_tx.sv
// SD host CMD-line transmitter: 48-bit frame with serial CRC7.
// Define SD_CMD_TX_NCC_EN to append 8 high Ncc bit periods.
module sd_cmd_tx
  import sd_cmd_pkg::*;
#(
  parameter int FRAME_W = CMD_FRAME_W,
  parameter int CRC_W   = CMD_CRC_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] argument,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done
);

  localparam int SR_W = FRAME_W - CRC_W - 1;

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  nxt;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic              out_q, out_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              crc_clr;
  logic              crc_en;
  logic              crc_din;
  logic [6:0]        crc;
  logic              unused_crc;

`ifdef SD_CMD_TX_NCC_EN
  localparam int NCC_W = $clog2(NCC_TICKS);
  logic [NCC_W-1:0]  ncc_q, ncc_d;
`endif

  sd_crc7_serial u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (crc_din),
    .crc (crc)
  );

  assign unused_crc = ^crc[CRC_W-2:0];
  assign nxt        = cnt_q - 1'b1;

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    out_d   = out_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_din = 1'b0;
`ifdef SD_CMD_TX_NCC_EN
    ncc_d   = ncc_q;
`endif
    unique case (state_q)
      IDLE: begin
        out_d  = 1'b1;
        oe_d   = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          sr_d    = {START_BIT, TX_BIT, cmd_index, argument};
          crc_clr = 1'b1;
          cnt_d   = CNT_W'(FRAME_W - 1);
          busy_d  = 1'b1;
          oe_d    = 1'b1;
          state_d = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (tick) begin
          out_d   = sr_q[SR_W-1];
          sr_d    = {sr_q[SR_W-2:0], 1'b0};
          crc_en  = 1'b1;
          crc_din = sr_q[SR_W-1];
          state_d = SEND;
        end
      end
      SEND: begin
        if (tick) begin
          if (cnt_q == '0) begin
`ifdef SD_CMD_TX_NCC_EN
            out_d   = 1'b1;
            ncc_d   = '0;
            state_d = NCC;
`else
            out_d   = 1'b1;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
`endif
          end else begin
            cnt_d = nxt;
            if (nxt > CNT_W'(CRC_W)) begin
              out_d   = sr_q[SR_W-1];
              sr_d    = {sr_q[SR_W-2:0], 1'b0};
              crc_en  = 1'b1;
              crc_din = sr_q[SR_W-1];
            end else if (nxt != '0) begin
              out_d   = crc[CRC_W-1];
              crc_en  = 1'b1;
              crc_din = crc[CRC_W-1];
            end else begin
              out_d = END_BIT;
            end
          end
        end
      end
      NCC: begin
`ifdef SD_CMD_TX_NCC_EN
        if (tick) begin
          if (ncc_q == NCC_W'(NCC_TICKS - 1)) begin
            out_d   = 1'b1;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            ncc_d = ncc_q + 1'b1;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      out_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SD_CMD_TX_NCC_EN
  // Ncc trailer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ncc_q <= '0;
    end else begin
      ncc_q <= ncc_d;
    end
  end
`endif

  assign cmd_out = out_q;
  assign cmd_oe  = oe_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Self-checking bench for sd_cmd_tx: table vectors, corner
// sequences and random commands against a division-based CRC model.
module tb_sd_cmd_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] argument = '0;
  logic        cmd_out;
  logic        cmd_oe;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SD_CMD_TX_NCC_EN
  localparam int LAT = 57;
`else
  localparam int LAT = 49;
`endif

  always #5 clk = ~clk;

  sd_cmd_tx dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .cmd_index (cmd_index),
    .argument  (argument),
    .cmd_out   (cmd_out),
    .cmd_oe    (cmd_oe),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // CRC7 as remainder of m(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] frame_ref(input logic [5:0] idx,
                                            input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, crc7_ref(m), 1'b1};
  endfunction

  // Send one command; optionally re-pulse start at tick inj_at.
  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg,
                           input int per, input int inj_at,
                           output logic [47:0] got, output int done_t,
                           output int done_w, output bit hold_ok);
    int t;
    int ph;
    bit was;
    got = '1;
    done_t = -1;
    done_w = 0;
    hold_ok = 1'b1;
    t = 0;
    ph = 0;
    @(posedge clk); #1;
    cmd_index = idx;
    argument = arg;
    start = 1'b1;
    tick = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cmd_index = ~idx;
    argument = ~arg;
    if (!(busy && cmd_oe && cmd_out)) hold_ok = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick = (ph == per - 1);
      ph = (ph == per - 1) ? 0 : ph + 1;
      if (inj_at >= 0 && t == inj_at) begin
        start = 1'b1;
        cmd_index = 6'h11;
        argument = 32'hDEAD_BEEF;
      end
      was = tick;
      @(posedge clk); #1;
      start = 1'b0;
      if (was) t++;
      if (was && t >= 1 && t <= 48) got[48 - t] = cmd_out;
      if (done) begin
        done_w++;
        if (done_t < 0) done_t = t;
        if (cmd_oe || busy || !cmd_out) hold_ok = 1'b0;
      end else if (done_t >= 0) begin
        break;
      end else begin
        if (!(busy && cmd_oe)) hold_ok = 1'b0;
        if (t > 48 && !cmd_out) hold_ok = 1'b0;
      end
    end
    tick = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    int          per;
    logic [47:0] frame;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [47:0] got;
    logic [47:0] exp;
    int dt;
    int dw;
    bit ok;
    bit seen;
    logic [5:0] ridx;
    logic [31:0] rarg;

    vt[0] = '{6'd0,  32'h0000_0000, 1, 48'h40_0000_0000_95};
    vt[1] = '{6'd8,  32'h0000_01AA, 4, 48'h48_0000_01AA_87};
    vt[2] = '{6'd17, 32'h0000_0000, 2, 48'h51_0000_0000_55};
    vt[3] = '{6'd55, 32'h0000_0000, 3, 48'h77_0000_0000_65};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_out", 64'(cmd_out), 64'd1);
    chk("rst_cmd_oe", 64'(cmd_oe), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_frame(vt[i].idx, vt[i].arg, vt[i].per, -1, got, dt, dw, ok);
      chk($sformatf("vec%0d_frame", i), 64'(got), 64'(vt[i].frame));
      chk($sformatf("vec%0d_latency", i), 64'(dt), 64'(LAT));
      chk($sformatf("vec%0d_done_width", i), 64'(dw), 64'd1);
      chk($sformatf("vec%0d_hold", i), 64'(ok), 64'd1);
    end

    run_frame(6'd8, 32'h0000_01AA, 1, 20, got, dt, dw, ok);
    chk("restart_frame", 64'(got), 64'h48_0000_01AA_87);
    chk("restart_latency", 64'(dt), 64'(LAT));
    chk("restart_hold", 64'(ok), 64'd1);

    @(posedge clk); #1;
    cmd_index = 6'd0;
    argument = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tick = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_cmd_out", 64'(cmd_out), 64'd1);
    chk("abort_cmd_oe", 64'(cmd_oe), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    tick = 1'b0;
    chk("abort_no_done", 64'(seen), 64'd0);
    run_frame(6'd0, 32'h0, 1, -1, got, dt, dw, ok);
    chk("after_abort_frame", 64'(got), 64'h40_0000_0000_95);
    chk("after_abort_latency", 64'(dt), 64'(LAT));

    for (int k = 0; k < 20; k++) begin
      ridx = 6'($urandom);
      rarg = $urandom;
      exp = frame_ref(ridx, rarg);
      run_frame(ridx, rarg, int'($urandom_range(1, 3)), -1, got, dt, dw, ok);
      chk($sformatf("rand%0d_frame", k), 64'(got), 64'(exp));
      chk($sformatf("rand%0d_latency", k), 64'(dt), 64'(LAT));
      chk($sformatf("rand%0d_misc", k), 64'({ok, 8'(dw)}), 64'({1'b1, 8'd1}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
